// File: rtl/fmap_rd_seq_pkg.sv
// Shared constants for the feature-map read sequencer: FSM state
// encodings and output-buffer sizing.
package fmap_rd_seq_pkg;

    // Sequencer states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_PAD = 2'd1;
    localparam logic [1:0] ST_READ     = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    // Output buffer depth and the width of its occupancy count (0..2)
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned BUF_CNT_W = 2;

endpackage

// File: rtl/fmap_skid_buf.sv
// Two-entry FIFO that holds scratch-pad words (plus their last flag)
// between the one-cycle read latency and the PE handshake. Entry 0 is
// always the head, so the head outputs only move on a pop.
module fmap_skid_buf
    import fmap_rd_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  valid_o,
    output logic [BUF_CNT_W-1:0]  count_o
);

    logic [BUF_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic                  pop_eff;

    // A pop is only meaningful when something is held
    assign pop_eff = pop_i && (cnt_q != '0);

    // Next-state for occupancy and entries: shift on pop, fill lowest free slot on push
    always_comb begin
        cnt_d   = cnt_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            case ({push_i, pop_eff})
                2'b10: begin
                    if (cnt_q == '0) begin
                        data0_d = data_i;
                        last0_d = last_i;
                    end else begin
                        data1_d = data_i;
                        last1_d = last_i;
                    end
                    cnt_d = cnt_q + BUF_CNT_W'(1);
                end
                2'b01: begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    cnt_d   = cnt_q - BUF_CNT_W'(1);
                end
                2'b11: begin
                    if (cnt_q == BUF_CNT_W'(1)) begin
                        data0_d = data_i;
                        last0_d = last_i;
                    end else begin
                        data0_d = data1_q;
                        last0_d = last1_q;
                        data1_d = data_i;
                        last1_d = last_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Occupancy is control state and is cleared by reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Payload registers carry no reset; they are masked by valid at the output
    always_ff @(posedge clk_i) begin
        data0_q <= data0_d;
        data1_q <= data1_d;
        last0_q <= last0_d;
        last1_q <= last1_d;
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? data0_q : '0;
    assign last_o  = valid_o && last0_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/fmap_rd_seq.sv
// Feature-map read sequencer: walks out_num windows of weight_num words
// each through the scratch pad (window bases step by stride) and streams
// the returned words to the PE over a valid/ready interface, marking the
// last word of every window.
module fmap_rd_seq
    import fmap_rd_seq_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDRESSWIDTH_F_PAD = 8,
    parameter int ADDRESSWIDTH_W_PAD = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_point,
    input  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] out_num,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] stride,
    input  logic                          pad_data_ready,
    output logic [ADDRESSWIDTH_F_PAD-1:0] raddra_ifmap,
    input  logic [DATA_WIDTH-1:0]         fmap_out,
    output logic [DATA_WIDTH-1:0]         pe_data,
    output logic                          pe_valid,
    input  logic                          pe_ready,
    output logic                          pe_last,
    output logic                          busy,
    output logic                          done
);

    localparam int AW = ADDRESSWIDTH_F_PAD;
    localparam int WW = ADDRESSWIDTH_W_PAD;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [WW-1:0] k_q, k_d;
    logic [AW-1:0] w_q, w_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;

    logic [WW-1:0] wn_q, wn_d;
    logic [AW-1:0] on_q, on_d;
    logic [AW-1:0] stride_q, stride_d;
    logic          inflight_last_q, inflight_last_d;

    logic [BUF_CNT_W-1:0] buf_cnt;
    logic                 buf_valid;
    logic                 pop;
    logic [2:0]           occ;
    logic                 credit_ok;
    logic                 k_last;
    logic                 w_last;
    logic                 issue;

    assign pop = buf_valid && pe_ready;

    // Occupancy after this cycle's pop: counting the departing word lets a
    // read issue every cycle in steady state while never exceeding two
    // words held or owed to the buffer.
    assign occ       = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = (occ < 3'd2);

    assign k_last = (k_q == wn_q - WW'(1));
    assign w_last = (w_q == on_q - AW'(1));
    assign issue  = (state_q == ST_READ) && pad_data_ready && credit_ok && !abort;

    // Window base already holds pixel_point + w*stride, so only k is added
    assign raddra_ifmap = base_q + AW'(k_q);

    // Sequencer next-state: parameter latch, counter walk, drain and abort
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        k_d             = k_q;
        w_d             = w_q;
        wn_d            = wn_q;
        on_d            = on_q;
        stride_d        = stride_q;
        inflight_d      = issue;
        inflight_last_d = k_last;
        done_d          = 1'b0;
        if (abort) begin
            state_d    = ST_IDLE;
            inflight_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        wn_d     = weight_num;
                        on_d     = out_num;
                        stride_d = stride;
                        base_d   = pixel_point;
                        k_d      = '0;
                        w_d      = '0;
                        if ((weight_num == '0) || (out_num == '0)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_PAD;
                        end
                    end
                end
                ST_WAIT_PAD: begin
                    if (pad_data_ready) begin
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        if (k_last) begin
                            k_d    = '0;
                            w_d    = w_q + AW'(1);
                            base_d = base_q + stride_q;
                            if (w_last) begin
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            k_d = k_q + WW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((buf_cnt == '0) && !inflight_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            k_q        <= '0;
            w_q        <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            k_q        <= k_d;
            w_q        <= w_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    // Latched parameters and the in-flight last tag need no reset
    always_ff @(posedge clk) begin
        wn_q            <= wn_d;
        on_q            <= on_d;
        stride_q        <= stride_d;
        inflight_last_q <= inflight_last_d;
    end

    fmap_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i   (clk),
        .rst_n_i (rst),
        .flush_i (abort),
        .push_i  (inflight_q),
        .data_i  (fmap_out),
        .last_i  (inflight_last_q),
        .pop_i   (pop),
        .data_o  (pe_data),
        .last_o  (pe_last),
        .valid_o (buf_valid),
        .count_o (buf_cnt)
    );

    assign pe_valid = buf_valid;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_fmap_rd_seq.sv
// Scoreboard bench for fmap_rd_seq: the stimulus process queues the
// expected PE words; a monitor pops and compares on every PE handshake.
module tb_fmap_rd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  pixel_point;
    logic [7:0]  weight_num;
    logic [7:0]  out_num;
    logic [7:0]  stride;
    logic        pad_data_ready;
    logic [7:0]  raddra_ifmap;
    logic [15:0] fmap_out;
    logic [15:0] pe_data;
    logic        pe_valid;
    logic        pe_ready;
    logic        pe_last;
    logic        busy;
    logic        done;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    logic [16:0] exp_q[$];
    bit          pad_mode = 1'b0;
    int          pad_ph = 0;

    fmap_rd_seq dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .pixel_point    (pixel_point),
        .weight_num     (weight_num),
        .out_num        (out_num),
        .stride         (stride),
        .pad_data_ready (pad_data_ready),
        .raddra_ifmap   (raddra_ifmap),
        .fmap_out       (fmap_out),
        .pe_data        (pe_data),
        .pe_valid       (pe_valid),
        .pe_ready       (pe_ready),
        .pe_last        (pe_last),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [7:0] a);
        return {a ^ 8'hC3, a};
    endfunction

    // Scratch pad: data one cycle after the address; a read taken while the
    // pad is not ready returns poison so it shows up in the scoreboard.
    always @(posedge clk) begin
        fmap_out <= pad_data_ready ? pat(raddra_ifmap) : 16'hDEAD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pad_mode) begin
            pad_data_ready = (pad_ph == 0);
            pad_ph = (pad_ph + 1) % 3;
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic last);
        exp_q.push_back({last, pat(a)});
    endtask

    task automatic push_036();
        push_exp(8'd0, 1'b0); push_exp(8'd1, 1'b0); push_exp(8'd2, 1'b1);
        push_exp(8'd1, 1'b0); push_exp(8'd2, 1'b0); push_exp(8'd3, 1'b1);
    endtask

    // Issues the start pulse; returns just after the edge that samples it
    task automatic do_start(input logic [7:0] pp, input logic [7:0] wn,
                            input logic [7:0] on, input logic [7:0] st);
        pixel_point = pp; weight_num = wn; out_num = on; stride = st;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, {31'd0, busy}, 32'd0);
        tick();
        tick();
    endtask

    // Monitor: count done pulses and score every accepted PE word
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (pe_valid === 1'b1 && pe_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pe_word: got unexpected %0h, required no word", {pe_last, pe_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("pe_word", {15'd0, pe_last, pe_data}, {15'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [15:0] held;
        logic [7:0] ahold;

        rst = 1'b0; start = 1'b0; abort = 1'b0;
        pixel_point = '0; weight_num = '0; out_num = '0; stride = '0;
        pad_data_ready = 1'b1; pe_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_pe_valid", {31'd0, pe_valid}, 32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_raddr",    {24'd0, raddra_ifmap}, 32'd0);
        chk("rst_pe_data",  {16'd0, pe_data},  32'd0);
        chk("rst_pe_last",  {31'd0, pe_last},  32'd0);
        rst = 1'b1;
        tick();

        // Basic two-window run with latency and throughput
        d0 = done_cnt;
        push_036();
        do_start(8'd0, 8'd3, 8'd2, 8'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_lat_e0", {31'd0, pe_valid}, 32'd0);
        tick();
        chk("t1_lat_e1", {31'd0, pe_valid}, 32'd0);
        chk("t1_first_addr", {24'd0, raddra_ifmap}, 32'd0);
        tick();
        chk("t1_lat_e2", {31'd0, pe_valid}, 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("t1_thru", {31'd0, pe_valid}, 32'd1);
            if (i < 5) tick();
        end
        wait_idle("t1", 50);
        chk("t1_done_cnt", done_cnt - d0, 32'd1);
        chk("t1_queue_empty", exp_q.size(), 32'd0);

        // Address arithmetic near the top of the address space
        d0 = done_cnt;
        push_exp(8'd250, 1'b0); push_exp(8'd251, 1'b0);
        push_exp(8'd252, 1'b0); push_exp(8'd253, 1'b1);
        do_start(8'd250, 8'd4, 8'd1, 8'd0);
        wait_idle("t2", 50);
        chk("t2_done_cnt", done_cnt - d0, 32'd1);
        chk("t2_queue_empty", exp_q.size(), 32'd0);

        // Wrap past 255, with a start while busy that must be ignored
        d0 = done_cnt;
        push_exp(8'd254, 1'b0); push_exp(8'd255, 1'b0);
        push_exp(8'd0, 1'b0);   push_exp(8'd1, 1'b1);
        do_start(8'd254, 8'd4, 8'd1, 8'd3);
        tick();
        do_start(8'd100, 8'd2, 8'd2, 8'd5);
        wait_idle("t3", 50);
        chk("t3_done_cnt", done_cnt - d0, 32'd1);
        chk("t3_queue_empty", exp_q.size(), 32'd0);

        // Back-pressure for ten cycles mid-window
        d0 = done_cnt;
        push_036();
        do_start(8'd0, 8'd3, 8'd2, 8'd1);
        tick(); tick(); tick(); tick();
        pe_ready = 1'b0;
        held  = pe_data;
        ahold = raddra_ifmap;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_stall_valid", {31'd0, pe_valid}, 32'd1);
            chk("t4_stall_data", {16'd0, pe_data}, {16'd0, held});
            chk("t4_stall_addr", {24'd0, raddra_ifmap}, {24'd0, ahold});
        end
        pe_ready = 1'b1;
        wait_idle("t4", 50);
        chk("t4_done_cnt", done_cnt - d0, 32'd1);
        chk("t4_queue_empty", exp_q.size(), 32'd0);

        // Scratch pad ready only one cycle in three
        d0 = done_cnt;
        push_036();
        pad_ph = 0;
        pad_mode = 1'b1;
        do_start(8'd0, 8'd3, 8'd2, 8'd1);
        wait_idle("t5", 100);
        pad_mode = 1'b0;
        pad_data_ready = 1'b1;
        chk("t5_done_cnt", done_cnt - d0, 32'd1);
        chk("t5_queue_empty", exp_q.size(), 32'd0);

        // Empty jobs: done pulse only, never busy
        for (int j = 0; j < 2; j++) begin
            d0 = done_cnt;
            if (j == 0) do_start(8'd5, 8'd0, 8'd2, 8'd1);
            else        do_start(8'd5, 8'd3, 8'd0, 8'd1);
            chk("t6_done_hi", {31'd0, done}, 32'd1);
            chk("t6_busy0", {31'd0, busy}, 32'd0);
            tick();
            chk("t6_done_lo", {31'd0, done}, 32'd0);
            chk("t6_busy1", {31'd0, busy}, 32'd0);
            chk("t6_no_valid", {31'd0, pe_valid}, 32'd0);
            tick();
            chk("t6_done_cnt", done_cnt - d0, 32'd1);
        end

        // Abort while the 4th word is presented
        d0 = done_cnt;
        push_exp(8'd0, 1'b0); push_exp(8'd1, 1'b0); push_exp(8'd2, 1'b1);
        do_start(8'd0, 8'd3, 8'd2, 8'd1);
        for (int i = 0; i < 6; i++) tick();
        abort = 1'b1;
        pe_ready = 1'b0;
        tick();
        abort = 1'b0;
        chk("t7_valid0", {31'd0, pe_valid}, 32'd0);
        chk("t7_busy0",  {31'd0, busy},     32'd0);
        chk("t7_done0",  {31'd0, done},     32'd0);
        pe_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t7_stay_empty", {31'd0, pe_valid}, 32'd0);
        end
        chk("t7_no_done", done_cnt - d0, 32'd0);
        chk("t7_queue_empty", exp_q.size(), 32'd0);

        // Abort has priority over a simultaneous start
        d0 = done_cnt;
        abort = 1'b1;
        do_start(8'd0, 8'd3, 8'd2, 8'd1);
        abort = 1'b0;
        chk("t7b_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t7b_busy2", {31'd0, busy}, 32'd0);
        chk("t7b_no_done", done_cnt - d0, 32'd0);

        // Asynchronous reset in the middle of a read sequence
        do_start(8'd0, 8'd3, 8'd2, 8'd1);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("t8_busy",  {31'd0, busy},     32'd0);
        chk("t8_valid", {31'd0, pe_valid}, 32'd0);
        chk("t8_done",  {31'd0, done},     32'd0);
        chk("t8_raddr", {24'd0, raddra_ifmap}, 32'd0);
        chk("t8_data",  {16'd0, pe_data},  32'd0);
        chk("t8_last",  {31'd0, pe_last},  32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t8_idle_after", {31'd0, busy}, 32'd0);
        d0 = done_cnt;
        push_036();
        do_start(8'd0, 8'd3, 8'd2, 8'd1);
        wait_idle("t8", 50);
        chk("t8_done_cnt", done_cnt - d0, 32'd1);
        chk("t8_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
